// File: rtl/mousetrap_sync_sink_pkg.sv
// Shared constants and helpers for the MouseTrap synchronous sink.
// Two-phase channels carry one token per transition; a token is pending while req and ack differ.
package mousetrap_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic logic token_pending(input logic req, input logic ack);
    return req != ack;
  endfunction

endpackage

// File: rtl/mousetrap_sync_sink_if.sv
// Bundled-data input channel and valid/ready output channel of the sink.
interface mousetrap_sync_sink_if
  import mousetrap_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
);
  localparam int COUNT_WIDTH = clog2(FIFO_DEPTH) + 1;

  logic                   req_in;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   ack_out;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] count;

  modport master (
    output req_in, data_in, out_ready,
    input  ack_out, out_valid, out_data, count
  );

  modport slave (
    input  req_in, data_in, out_ready,
    output ack_out, out_valid, out_data, count
  );

endinterface

// File: rtl/two_phase_sync.sv
// Flop-chain synchronizer for a transition-signalled request line.
module two_phase_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = async_i;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mousetrap_sync_sink.sv
// Receives MouseTrap two-phase bundled-data tokens, acknowledges each capture,
// and buffers them in a small FIFO presented on a synchronous valid/ready port.
module mousetrap_sync_sink
  import mousetrap_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mousetrap_sync_sink_if.slave bus_if
);

  localparam int PTR_W   = clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic                  req_s;
  logic                  ack_q, ack_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [COUNT_W-1:0]    readable;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  pending, pop, full, capture;

  two_phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (bus_if.req_in),
    .sync_o  (req_s)
  );

  // A slot freed by a pop on this edge can be refilled on the same edge.
  always_comb begin
    pending     = token_pending(req_s, ack_q);
    pop         = out_valid_q && bus_if.out_ready;
    full        = (count_q == COUNT_W'(FIFO_DEPTH));
    capture     = pending && (!full || pop);
    ack_d       = ack_q ^ capture;
    wr_ptr_d    = wr_ptr_q + PTR_W'(capture);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + COUNT_W'(capture) - COUNT_W'(pop);
    // Only words written on earlier edges feed the output register.
    readable    = count_q - COUNT_W'(pop);
    out_valid_d = (readable != '0);
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      mem[wr_ptr_q] <= bus_if.data_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ack_q       <= ack_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        out_data_q <= mem[rd_ptr_d];
      end
    end
  end

  assign bus_if.ack_out   = ack_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.count     = count_q;

endmodule

// File: tb/tb_mousetrap_sync_sink.sv
// Scoreboard bench: an upstream token driver feeds an expected-word queue that a monitor drains.
module tb_mousetrap_sync_sink;
  import mousetrap_pkg::*;

  localparam int DW    = 8;
  localparam int SS    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mousetrap_sync_sink_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_if ();

  mousetrap_sync_sink #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if)
  );

  int            checks     = 0;
  int            failures   = 0;
  int            pops_total = 0;
  int            acks_total = 0;
  int            ready_mode = 0;
  logic          ack_prev   = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end else begin
      $display("ok   %s act=%0d", name, act);
    end
  endtask

  // Downstream readiness: 0 = stall, 1 = always ready, otherwise random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus_if.out_ready = 1'b0;
      1:       bus_if.out_ready = 1'b1;
      default: bus_if.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every accepted word must be the oldest word still expected.
  always @(negedge clk) begin
    if (rst) begin
      ack_prev = 1'b0;
    end else begin
      if (bus_if.ack_out != ack_prev) acks_total++;
      ack_prev = bus_if.ack_out;
      checks++;
      if (int'(bus_if.count) > DEPTH) begin
        failures++;
        $display("FAIL count_bound act=%0d max=%0d", bus_if.count, DEPTH);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        pops_total++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data act=%02h exp=none", bus_if.out_data);
        end else begin
          chk("out_data", int'(bus_if.out_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic [DW-1:0] d);
    bus_if.data_in = d;
    bus_if.req_in  = ~bus_if.req_in;
    exp_q.push_back(d);
    $display("send data=%02h req=%0b", d, bus_if.req_in);
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (bus_if.ack_out != bus_if.req_in && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus_if.ack_out != bus_if.req_in) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout act=%0b exp=%0b", bus_if.ack_out, bus_if.req_in);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("drain_count", int'(bus_if.count), 0);
    ready_mode = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    int   a0;
    int   p0;
    logic old_ack;

    bus_if.req_in  = 1'b0;
    bus_if.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ack", int'(bus_if.ack_out), 0);
    chk("rst_valid", int'(bus_if.out_valid), 0);
    chk("rst_data", int'(bus_if.out_data), 0);
    chk("rst_count", int'(bus_if.count), 0);

    // Single token latency
    issue(8'hA5);
    wait_ack(10, n);
    chk("ack_latency", n, SS + 1);
    @(negedge clk);
    chk("valid_after_ack", int'(bus_if.out_valid), 0);
    chk("count_after_ack", int'(bus_if.count), 1);
    @(posedge clk); #1;
    chk("valid_next", int'(bus_if.out_valid), 1);
    chk("data_next", int'(bus_if.out_data), 8'hA5);
    drain(20);

    // Burst into a stalled FIFO, then full + simultaneous pop
    for (int i = 1; i <= DEPTH; i++) begin
      issue(DW'(i));
      wait_ack(20, n);
    end
    @(posedge clk); #1;
    chk("burst_count", int'(bus_if.count), DEPTH);
    old_ack = bus_if.ack_out;
    issue(8'h05);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("full_hold_ack", int'(bus_if.ack_out), int'(old_ack));
    chk("full_hold_count", int'(bus_if.count), DEPTH);
    p0 = pops_total;
    ready_mode = 1;
    wait_ack(10, n);
    chk("full_pop_pops", pops_total - p0, 1);
    chk("full_pop_count", int'(bus_if.count), DEPTH);
    drain(50);

    // Wrap-around with random stalls
    ready_mode = 2;
    for (int i = 0; i < 12; i++) begin
      issue(DW'($urandom_range(0, 255)));
      wait_ack(200, n);
    end
    drain(100);

    // Reset mid-operation
    issue(8'h11);
    wait_ack(20, n);
    issue(8'h22);
    wait_ack(20, n);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_count", int'(bus_if.count), 2);
    rst = 1'b1;
    bus_if.req_in = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", int'(bus_if.out_valid), 0);
    chk("midrst_count", int'(bus_if.count), 0);
    chk("midrst_ack", int'(bus_if.ack_out), 0);
    issue(8'h3C);
    wait_ack(10, n);
    chk("post_rst_latency", n, SS + 1);
    drain(20);

    // Steady ReqIn must not produce extra captures
    a0 = acks_total;
    repeat (50) begin
      @(posedge clk); #1;
    end
    chk("idle_no_ack", acks_total - a0, 0);
    ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      a0 = acks_total;
      issue(DW'($urandom_range(0, 255)));
      repeat (50) begin
        @(posedge clk); #1;
      end
      chk("one_capture", acks_total - a0, 1);
    end
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
